// File: rtl/seq_arb_pkg.sv
// Shared state encoding and ID-width helper for the sequence-detector arbiter.
package seq_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CLEAR  = 2'd1,
      STREAM = 2'd2,
      REPORT = 2'd3
   } seq_arb_state_t;

   // Width needed to hold a requester index; never narrower than one bit.
   function automatic int id_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/seq_detect_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping.
module rr_pick import seq_arb_pkg::*; #(
   parameter int  NUM_REQ = 4,
   localparam int IDW     = id_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDW-1:0]     ptr,
   output logic [IDW-1:0]     idx,
   output logic               valid
);

   logic [NUM_REQ-1:0] rot;
   logic [IDW-1:0]     off;
   logic [IDW:0]       sum;

   always_comb begin
      // Rotate so bit 0 is the requester at ptr; lowest set bit is the winner.
      rot   = NUM_REQ'({req, req} >> ptr);
      off   = '0;
      valid = 1'b0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (rot[k]) begin
            off   = k[IDW-1:0];
            valid = 1'b1;
         end
      end
      sum = {1'b0, ptr} + {1'b0, off};
      if (sum >= (IDW+1)'(NUM_REQ)) begin
         sum = sum - (IDW+1)'(NUM_REQ);
      end
      idx = sum[IDW-1:0];
   end

endmodule

// File: rtl/seq_detect_arbiter.sv
// Round-robin arbiter sharing one serial Mealy sequence detector among NUM_REQ bit streams.
// Define SEQ_ARB_SAT_EN to make the per-frame hit counter saturate instead of wrapping.
module seq_detect_arbiter import seq_arb_pkg::*; #(
   parameter int  NUM_REQ   = 4,
   parameter int  FRAME_LEN = 16,
   parameter int  CNT_W     = 5,
   localparam int IDW       = id_w(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic [NUM_REQ-1:0] bit_in,
   output logic [NUM_REQ-1:0] grant,
   output logic               bit_strobe,
   output logic               det_in,
   output logic               det_rst,
   input  logic               det_out,
   output logic               done,
   output logic [IDW-1:0]     done_id,
   output logic [CNT_W-1:0]   match_count
);

   localparam int             BCW      = $clog2(FRAME_LEN) + 1;
   localparam logic [BCW-1:0] LAST_BIT = BCW'(FRAME_LEN - 1);

   seq_arb_state_t     state_q, state_d;
   logic [IDW-1:0]     owner_q, owner_d;
   logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
   logic [IDW-1:0]     done_id_q, done_id_d;
   logic [BCW-1:0]     bit_cnt_q, bit_cnt_d;
   logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
   logic [CNT_W-1:0]   match_count_q, match_count_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic               bit_strobe_q, bit_strobe_d;
   logic               done_q, done_d;
   logic [IDW-1:0]     pick_idx;
   logic               pick_valid;
   logic [CNT_W-1:0]   hit_next;

   function automatic logic [CNT_W-1:0] hit_bump(input logic [CNT_W-1:0] c);
`ifdef SEQ_ARB_SAT_EN
      return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
`else
      return c + 1'b1;
`endif
   endfunction

   function automatic logic [NUM_REQ-1:0] one_hot(input logic [IDW-1:0] i);
      return NUM_REQ'(1) << i;
   endfunction

   function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] o);
      return (o == IDW'(NUM_REQ - 1)) ? '0 : o + 1'b1;
   endfunction

   rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_pick (
      .req   (req),
      .ptr   (rr_ptr_q),
      .idx   (pick_idx),
      .valid (pick_valid)
   );

   assign hit_next = det_out ? hit_bump(hit_cnt_q) : hit_cnt_q;

   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      rr_ptr_d      = rr_ptr_q;
      bit_cnt_d     = bit_cnt_q;
      hit_cnt_d     = hit_cnt_q;
      done_id_d     = done_id_q;
      match_count_d = match_count_q;
      grant_d       = '0;
      bit_strobe_d  = 1'b0;
      done_d        = 1'b0;
      // Output flops are loaded with the values for the state being entered.
      unique case (state_q)
         IDLE: begin
            if (pick_valid) begin
               owner_d = pick_idx;
               grant_d = one_hot(pick_idx);
               state_d = CLEAR;
            end
         end
         CLEAR: begin
            bit_cnt_d    = '0;
            hit_cnt_d    = '0;
            grant_d      = one_hot(owner_q);
            bit_strobe_d = 1'b1;
            state_d      = STREAM;
         end
         STREAM: begin
            hit_cnt_d = hit_next;
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == LAST_BIT) begin
               done_d        = 1'b1;
               done_id_d     = owner_q;
               match_count_d = hit_next;
               state_d       = REPORT;
            end else begin
               grant_d      = one_hot(owner_q);
               bit_strobe_d = 1'b1;
            end
         end
         REPORT: begin
            rr_ptr_d = next_ptr(owner_q);
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         owner_q       <= '0;
         rr_ptr_q      <= '0;
         bit_cnt_q     <= '0;
         hit_cnt_q     <= '0;
         done_id_q     <= '0;
         match_count_q <= '0;
         grant_q       <= '0;
         bit_strobe_q  <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         owner_q       <= owner_d;
         rr_ptr_q      <= rr_ptr_d;
         bit_cnt_q     <= bit_cnt_d;
         hit_cnt_q     <= hit_cnt_d;
         done_id_q     <= done_id_d;
         match_count_q <= match_count_d;
         grant_q       <= grant_d;
         bit_strobe_q  <= bit_strobe_d;
         done_q        <= done_d;
      end
   end

   // The detector is cleared by the global reset as well as before every frame.
   assign det_rst     = rst | (state_q == CLEAR);
   assign det_in      = (state_q == STREAM) ? bit_in[owner_q] : 1'b0;
   assign grant       = grant_q;
   assign bit_strobe  = bit_strobe_q;
   assign done        = done_q;
   assign done_id     = done_id_q;
   assign match_count = match_count_q;

endmodule

// File: tb/tb_seq_detect_arbiter.sv
// Bench for seq_detect_arbiter: two instances (CNT_W=5 and CNT_W=1) each driving a
// behavioural non-overlapping "1011" Mealy detector, checked against a frame-level model.
module tb_seq_detect_arbiter;

   localparam int N = 4;
   localparam int F = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = '0;
   logic [3:0] bit_in = '0;

   logic [3:0] grant0, grant1;
   logic       bit_strobe0, bit_strobe1, det_in0, det_in1, det_rst0, det_rst1;
   logic       det_out0, det_out1, done0, done1;
   logic [1:0] done_id0, done_id1;
   logic [4:0] match_count0;
   logic [0:0] match_count1;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   seq_detect_arbiter #(.NUM_REQ(N), .FRAME_LEN(F), .CNT_W(5)) dut0 (
      .clk(clk), .rst(rst), .req(req), .bit_in(bit_in), .grant(grant0),
      .bit_strobe(bit_strobe0), .det_in(det_in0), .det_rst(det_rst0), .det_out(det_out0),
      .done(done0), .done_id(done_id0), .match_count(match_count0));

   seq_detect_arbiter #(.NUM_REQ(N), .FRAME_LEN(F), .CNT_W(1)) dut1 (
      .clk(clk), .rst(rst), .req(req), .bit_in(bit_in), .grant(grant1),
      .bit_strobe(bit_strobe1), .det_in(det_in1), .det_rst(det_rst1), .det_out(det_out1),
      .done(done1), .done_id(done_id1), .match_count(match_count1));

   // Detector "1011", non-overlapping: return to the empty prefix after a hit.
   int d0_st = 0;
   int d1_st = 0;

   function automatic int dnext(input int st, input logic b);
      case (st)
         0:       return b ? 1 : 0;
         1:       return b ? 1 : 2;
         2:       return b ? 3 : 0;
         default: return b ? 0 : 2;
      endcase
   endfunction

   assign det_out0 = (d0_st == 3) && det_in0;
   assign det_out1 = (d1_st == 3) && det_in1;

   always @(posedge clk or posedge det_rst0)
      if (det_rst0) d0_st <= 0; else d0_st <= dnext(d0_st, det_in0);
   always @(posedge clk or posedge det_rst1)
      if (det_rst1) d1_st <= 0; else d1_st <= dnext(d1_st, det_in1);

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Count non-overlapping "1011" occurrences by direct string scan.
   function automatic int count_1011(input logic bits[$]);
      int c = 0;
      int i = 0;
      while (i + 4 <= bits.size()) begin
         if (bits[i] && !bits[i+1] && bits[i+2] && bits[i+3]) begin
            c++;
            i += 4;
         end else begin
            i++;
         end
      end
      return c;
   endfunction

   // Frame-level model: t counts cycles since the IDLE cycle that saw req.
   int         m_busy = 0, m_t = 0, m_owner = 0, m_ptr = 0, m_id = 0, m_cnt = 0, m_cnt1 = 0;
   logic       m_bits[$];
   logic [3:0] e_grant;
   logic       e_strobe, e_din, e_drst, e_done;
   logic       adv[4];
   int         dl_id[$], dl_cnt[$], dl_cnt1[$], dl_cyc[$];
   int         gcnt = 0, drst_cnt = 0, scnt = 0;

   always @(negedge clk) begin
      if (rst) begin
         chk("rst_grant", grant0, 0);
         chk("rst_strobe", bit_strobe0, 0);
         chk("rst_det_in", det_in0, 0);
         chk("rst_det_rst", det_rst0, 1);
         chk("rst_done", done0, 0);
         chk("rst_done_id", done_id0, 0);
         chk("rst_match", match_count0, 0);
         chk("rst_match1", match_count1, 0);
         m_busy = 0; m_t = 0; m_ptr = 0; m_id = 0; m_cnt = 0; m_cnt1 = 0;
         for (int r = 0; r < N; r++) adv[r] = 1'b0;
      end else begin
         e_grant = '0; e_strobe = 0; e_din = 0; e_drst = 0; e_done = 0;
         if (m_busy != 0) begin
            if (m_t == 1) begin
               e_grant = 4'(1 << m_owner);
               e_drst  = 1'b1;
               m_bits.delete();
            end else if (m_t <= F + 1) begin
               e_grant  = 4'(1 << m_owner);
               e_strobe = 1'b1;
               e_din    = bit_in[m_owner];
               m_bits.push_back(bit_in[m_owner]);
            end else begin
               int n;
               n      = count_1011(m_bits);
               e_done = 1'b1;
               m_id   = m_owner;
               m_cnt  = n % 32;
`ifdef SEQ_ARB_SAT_EN
               m_cnt1 = (n > 0) ? 1 : 0;
`else
               m_cnt1 = n % 2;
`endif
               m_ptr  = (m_owner + 1) % N;
               m_busy = 0;
            end
            m_t++;
         end else if (req != 0) begin
            m_owner = -1;
            for (int i = 0; i < N; i++)
               if (m_owner < 0 && req[(m_ptr + i) % N]) m_owner = (m_ptr + i) % N;
            m_busy = 1;
            m_t    = 1;
         end
         chk("grant", grant0, e_grant);
         chk("bit_strobe", bit_strobe0, e_strobe);
         chk("det_in", det_in0, e_din);
         chk("det_rst", det_rst0, e_drst);
         chk("done", done0, e_done);
         chk("done_id", done_id0, m_id);
         chk("match_count", match_count0, m_cnt);
         chk("grant_w1", grant1, e_grant);
         chk("done_w1", done1, e_done);
         chk("match_count_w1", match_count1, m_cnt1);
         if (done0) begin
            dl_id.push_back(done_id0);
            dl_cnt.push_back(match_count0);
            dl_cnt1.push_back(match_count1);
            dl_cyc.push_back(cyc);
         end
         if (grant0 != 0) gcnt++;
         if (det_rst0) drst_cnt++;
         if (bit_strobe0) scnt++;
         for (int r = 0; r < N; r++) adv[r] = bit_strobe0 && grant0[r];
      end
   end

   // Bit sources: each requester shifts out an 8-bit pattern MSB first, one bit per strobe.
   logic [7:0] pat[4];
   int         sidx[4];

   task automatic drive_bits();
      for (int r = 0; r < N; r++)
         bit_in[r] = (sidx[r] < 8) ? pat[r][3'(7 - sidx[r])] : 1'b0;
   endtask

   task automatic load(input int r, input logic [7:0] p);
      pat[r]  = p;
      sidx[r] = 0;
      drive_bits();
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      for (int r = 0; r < N; r++) if (adv[r]) sidx[r]++;
      drive_bits();
   endtask

   task automatic wait_done(input int n);
      int k = 0;
      while (dl_id.size() < n && k < 60) begin
         tick();
         k++;
      end
      if (dl_id.size() < n) chk("done_timeout", dl_id.size(), n);
   endtask

   int base, c0;

   initial begin
      for (int r = 0; r < N; r++) begin
         pat[r]  = '0;
         sidx[r] = 8;
         adv[r]  = 1'b0;
      end
      drive_bits();
      rst = 1'b1;
      repeat (3) tick();
      chk("init_grant", grant0, 0);
      chk("init_det_rst", det_rst0, 1);
      chk("init_done", done0, 0);
      chk("init_match", match_count0, 0);
      rst = 1'b0;
      repeat (2) tick();

      // All four requesting: grants rotate 0,1,2,3,0 with an 11-cycle done period.
      load(0, 8'b10111011);
      load(1, 8'b10110000);
      load(2, 8'b00001011);
      load(3, 8'b11111111);
      base = dl_id.size();
      c0   = cyc;
      req  = 4'b1111;
      wait_done(base + 4);
      tick();
      req = 4'b0000;
      wait_done(base + 5);
      if (dl_id.size() >= base + 5) begin
         chk("rr_first_latency", dl_cyc[base] - c0, 10);
         chk("rr_id0", dl_id[base], 0);
         chk("rr_id1", dl_id[base+1], 1);
         chk("rr_id2", dl_id[base+2], 2);
         chk("rr_id3", dl_id[base+3], 3);
         chk("rr_id4", dl_id[base+4], 0);
         chk("rr_cnt0", dl_cnt[base], 2);
         chk("rr_cnt1", dl_cnt[base+1], 1);
         chk("rr_cnt2", dl_cnt[base+2], 1);
         chk("rr_cnt3", dl_cnt[base+3], 0);
         for (int i = 0; i < 4; i++) chk("rr_gap", dl_cyc[base+i+1] - dl_cyc[base+i], 11);
      end

      // Single requester 0, stream 10111011.
      load(0, 8'b10111011);
      gcnt = 0; drst_cnt = 0;
      base = dl_id.size();
      c0   = cyc;
      req  = 4'b0001;
      tick();
      req = 4'b0000;
      wait_done(base + 1);
      if (dl_id.size() >= base + 1) begin
         chk("single_latency", dl_cyc[base] - c0, 10);
         chk("single_id", dl_id[base], 0);
         chk("single_cnt", dl_cnt[base], 2);
`ifdef SEQ_ARB_SAT_EN
         chk("single_cnt_w1_sat", dl_cnt1[base], 1);
`else
         chk("single_cnt_w1_wrap", dl_cnt1[base], 0);
`endif
      end
      chk("single_grant_cycles", gcnt, 9);
      chk("single_det_rst_pulses", drst_cnt, 1);

      // Requester 2: two back-to-back frames, one hit each.
      load(2, 8'b10110000);
      base = dl_id.size();
      req  = 4'b0100;
      tick();
      req = 4'b0000;
      wait_done(base + 1);
      load(2, 8'b00001011);
      req = 4'b0100;
      tick();
      req = 4'b0000;
      wait_done(base + 2);
      if (dl_id.size() >= base + 2) begin
         chk("clear_id_a", dl_id[base], 2);
         chk("clear_cnt_a", dl_cnt[base], 1);
         chk("clear_id_b", dl_id[base+1], 2);
         chk("clear_cnt_b", dl_cnt[base+1], 1);
      end

      // Requester 1 drops req in its second STREAM cycle; frame still runs to completion.
      load(1, 8'b01011011);
      scnt = 0;
      base = dl_id.size();
      req  = 4'b0010;
      repeat (3) tick();
      req = 4'b0000;
      wait_done(base + 1);
      if (dl_id.size() >= base + 1) begin
         chk("drop_id", dl_id[base], 1);
         chk("drop_cnt", dl_cnt[base], 1);
      end
      chk("drop_strobes", scnt, 8);

      // Reset in the 4th STREAM cycle of requester 2's frame.
      load(2, 8'b10111011);
      base = dl_id.size();
      req  = 4'b1111;
      repeat (5) tick();
      rst = 1'b1;
      req = 4'b0000;
      #1;
      chk("mid_rst_grant", grant0, 0);
      chk("mid_rst_strobe", bit_strobe0, 0);
      chk("mid_rst_det_rst", det_rst0, 1);
      chk("mid_rst_done_id", done_id0, 0);
      chk("mid_rst_match", match_count0, 0);
      repeat (2) tick();
      rst = 1'b0;
      repeat (4) tick();
      chk("mid_rst_no_done", dl_id.size(), base);
      load(0, 8'b10111011);
      load(1, 8'b11111111);
      load(2, 8'b11111111);
      load(3, 8'b11111111);
      req = 4'b1111;
      tick();
      req = 4'b0000;
      wait_done(base + 1);
      if (dl_id.size() >= base + 1) begin
         chk("post_rst_id", dl_id[base], 0);
         chk("post_rst_cnt", dl_cnt[base], 2);
      end
      repeat (3) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_detect_arbiter.md
# seq_detect_arbiter

Shares one serial sequence detector (the non-overlapping Mealy detector, `in`/`out` serial interface) among `NUM_REQ` bit-stream requesters. The arbiter grants the detector to one requester per frame, clears the detector's state before each frame, and steers that requester's serial bits into it for `FRAME_LEN` cycles. It counts detector hits and reports the per-frame match count with the owner's ID. It sits between the serial sources and the single detector instance.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `FRAME_LEN`, 16, bits per granted frame (≥1)
- `CNT_W`, 5, width of `match_count`
- `clk`  input  1  single clock, rising edge
- `rst`  input  1  asynchronous, active-high reset
- `req`  input  NUM_REQ  per-requester frame request, level
- `bit_in`  input  NUM_REQ  per-requester serial data bit
- `grant`  output  NUM_REQ  one-hot owner indication
- `bit_strobe`  output  1  high in each STREAM cycle; owner must present its next bit
- `det_in`  output  1  serial bit to detector `in`
- `det_rst`  output  1  reset to detector `rst`
- `det_out`  input  1  detector `out`, Mealy, same-cycle valid
- `done`  output  1  one-cycle frame-complete pulse
- `done_id`  output  $clog2(NUM_REQ)  owner of completed frame
- `match_count`  output  CNT_W  hits in completed frame

## Operation
- FSM states: IDLE, CLEAR, STREAM, REPORT.
- IDLE: if any `req` bit is high, select the winner round-robin, starting search at `rr_ptr`. At the edge, latch `owner` and go to CLEAR. Otherwise stay in IDLE.
- CLEAR: one cycle. `det_rst`=1 and `grant[owner]`=1. Zero the hit counter and bit counter. Go to STREAM.
- STREAM: exactly `FRAME_LEN` cycles.
  - `grant[owner]`=1, `bit_strobe`=1, `det_in`=`bit_in[owner]`.
  - Hit counter increments on each cycle with `det_out`=1.
  - After the last bit, go to REPORT.
- REPORT: one cycle.
  - `done`=1; `done_id`=owner; `match_count`=final count.
  - `rr_ptr`←owner+1 modulo NUM_REQ.
  - Always return to IDLE.
- `done_id` and `match_count` are registered and hold their values until the next REPORT.
- Dropping `req` mid-frame does not abort the frame. Non-owner `req`/`bit_in` are ignored until IDLE.
- `det_in`=0 outside STREAM. `det_rst` = `rst` OR (state==CLEAR), so the detector is also cleared by the global reset.
- Counter width: the hit counter is CNT_W bits. Overflow behaviour is set under Configuration.

## Timing
- Reset values: state IDLE, `rr_ptr`=0, `grant`=0, `bit_strobe`=0, `det_in`=0, `det_rst`=1 (follows `rst`), `done`=0, `done_id`=0, `match_count`=0.
- Latency, with `req` seen in IDLE at cycle 0:
  - CLEAR at cycle 1.
  - STREAM at cycles 2..FRAME_LEN+1.
  - `done` at cycle FRAME_LEN+2.
  - IDLE at FRAME_LEN+3.
  - Minimum frame-to-frame period is FRAME_LEN+3.
- Simultaneous requests: the first set bit at or after `rr_ptr` (wrapping) wins. No requester waits more than NUM_REQ−1 frames while holding `req`.
- A hit on the final STREAM bit is counted in that frame's `match_count`.
- `rst` asserted in any state:
  - Immediately forces state IDLE and clears all outputs and counters.
  - The partial frame is discarded and `done` does not fire.

## Configuration
- Macro `SEQ_ARB_SAT_EN`.
- Defined: the hit counter saturates at 2^CNT_W−1.
- Undefined: the hit counter wraps modulo 2^CNT_W.

## Structure
- Package `seq_arb_pkg`: state enum `seq_arb_state_t` (IDLE, CLEAR, STREAM, REPORT) and the ID-width function.
- One sub-module, `rr_pick`: combinational round-robin winner selection from `req` and `rr_ptr`, returning the index and a valid flag.
- The detector is instantiated outside this block.

## Test plan
All scenarios use NUM_REQ=4, FRAME_LEN=8, CNT_W=5, and the real detector configured for "1011".
- `req`=0001, requester 0 streams 10111011 → `grant`=0001 for 9 cycles, `det_rst` pulse in CLEAR, `done` at cycle 10 with `done_id`=0 and `match_count`=2.
- `req`=1111 held for 4 frames → grant order 0,1,2,3, then 0 again. Each gap between `done` pulses is 11 cycles.
- Requester 2 streams 10110000, then a new frame of 00001011 → `match_count`=1 each. The second frame has no carry-over hit from the first, confirming CLEAR.
- Assert `rst` at the 4th STREAM cycle → outputs return to reset values next sample. No `done` fires. The next frame starts from `rr_ptr`=0.
- CNT_W=1 with stream 10111011 → `match_count`=1 with `SEQ_ARB_SAT_EN` defined, 0 without it.
- Requester 1 drops `req` at STREAM cycle 2 → the frame completes with all 8 bits and `done_id`=1.
